// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam int PS2_DATA_BITS = 8;
    localparam int TIMEOUT_W     = 17;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level
);

    logic [1:0] r_sync;
    logic       r_level;
    logic [7:0] r_run;

    // NOTE: synchroniser and filter reset to 1 so an idle-high line produces no edge after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_run   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] != r_level) begin
                if (r_run == 8'(FILTER_LEN - 1)) begin
                    r_level <= r_sync[1];
                    r_run   <= 8'd0;
                end else begin
                    r_run <= r_run + 8'd1;
                end
            end else begin
                r_run <= 8'd0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 frame receiver producing scancode bytes with strobes for the keyboard matrix stage.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 56000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scancode,
    output logic       receiveflag,
    output logic       frame_err,
    output logic       parity_err
);
    import ps2_pkg::*;

    logic                     w_clk_f;
    logic                     w_dat_f;
    logic                     w_fall;
    logic                     w_timeout;

    ps2_state_e               r_state;
    logic [2:0]               r_bitcnt;
    logic [PS2_DATA_BITS-1:0] r_shift;
    logic [TIMEOUT_W-1:0]     r_timer;
    logic                     r_clk_prev;
    logic [7:0]               r_scancode;
    logic                     r_receiveflag;
    logic                     r_frame_err;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2_dat),
        .o_level (w_dat_f)
    );

    assign w_fall    = r_clk_prev & ~w_clk_f;
    assign w_timeout = (r_state != ST_IDLE) && (r_timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    logic r_parity_err;
    logic w_parity_ok;

    assign w_parity_ok = ^{r_shift, r_parity};
    assign parity_err  = r_parity_err;
`else
    assign parity_err  = 1'b0;
`endif

    // Timeout is evaluated first so a fall landing on the expiry cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bitcnt      <= 3'd0;
            r_shift       <= '0;
            r_timer       <= '0;
            r_clk_prev    <= 1'b1;
            r_scancode    <= 8'h00;
            r_receiveflag <= 1'b0;
            r_frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity      <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_clk_prev    <= w_clk_f;
            r_receiveflag <= 1'b0;
            r_frame_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_parity_err  <= 1'b0;
`endif
            if (r_state == ST_IDLE || w_fall) r_timer <= '0;
            else                              r_timer <= r_timer + 1'b1;

            if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_timer     <= '0;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_dat_f) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_dat_f, r_shift[PS2_DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_parity <= w_dat_f;
`endif
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (!w_dat_f) begin
                            r_frame_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                        end else if (!w_parity_ok) begin
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_scancode    <= r_shift;
                            r_receiveflag <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign scancode    = r_scancode;
    assign receiveflag = r_receiveflag;
    assign frame_err   = r_frame_err;

endmodule
